// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver: double-buffered digit codes, per-digit decode
// with leading-zero blanking, one digit per refresh slot, registered pin outputs.
module seg7_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 2,
  parameter int HEX_EN      = 1,
  parameter int SEG_ACT_LOW = 1,
  parameter int AN_ACT_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(DIGITS);
  localparam logic [6:0]        SEG_OFF = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic              DP_OFF  = (SEG_ACT_LOW != 0);
  localparam logic [DIGITS-1:0] AN_OFF  = (AN_ACT_LOW != 0) ? '1 : '0;

  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'h0: s = 7'h7E;  4'h1: s = 7'h30;  4'h2: s = 7'h6D;  4'h3: s = 7'h79;
      4'h4: s = 7'h33;  4'h5: s = 7'h5B;  4'h6: s = 7'h5F;  4'h7: s = 7'h70;
      4'h8: s = 7'h7F;  4'h9: s = 7'h7B;  4'hA: s = 7'h77;  4'hB: s = 7'h1F;
      4'hC: s = 7'h4E;  4'hD: s = 7'h3D;  4'hE: s = 7'h4F;  default: s = 7'h47;
    endcase
    if (code > 4'd9 && HEX_EN == 0) s = 7'h00;
    return s;
  endfunction

  logic [PW-1:0]              presc;
  logic [IW-1:0]              idx;
  logic                       en_d;
  logic [DIGITS-1:0][3:0]     pend_code, act_code, src_code;
  logic [DIGITS-1:0]          pend_dp, act_dp, src_dp, lz_blank, lane_dp;
  logic [DIGITS-1:0][6:0]     lane_seg;
  logic                       lz_run, slot_end, frame_end, in_blank;
  logic [DIGITS-1:0]          cur_an;

  assign slot_end  = (presc == PW'(REFRESH_DIV - 1));
  assign frame_end = slot_end && (idx == IW'(DIGITS - 1));
  assign in_blank  = int'(presc) < BLANK_CYC;

  // On the first enabled cycle the copy into act_* is still in flight, so show pending directly.
  assign src_code = en_d ? act_code : pend_code;
  assign src_dp   = en_d ? act_dp   : pend_dp;

  // A zero run from the top digit down; a set dp breaks the run at that digit.
  always_comb begin
    lz_blank = '0;
    lz_run   = 1'b1;
    for (int k = DIGITS - 1; k > 0; k--) begin
      lz_run      = lz_run && (src_code[k] == 4'd0) && !src_dp[k];
      lz_blank[k] = blank_lz && lz_run;
    end
  end

  genvar i;
  generate
    for (i = 0; i < DIGITS; i++) begin : g_lane
      assign lane_seg[i] = lz_blank[i] ? 7'h00 : decode(src_code[i]);
      assign lane_dp[i]  = src_dp[i] && !lz_blank[i];
    end
  endgenerate

  assign cur_an = in_blank ? '0 : (DIGITS'(1) << idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc      <= '0;
      idx        <= '0;
      en_d       <= 1'b0;
      pend_code  <= '0;
      pend_dp    <= '0;
      act_code   <= '0;
      act_dp     <= '0;
      seg        <= SEG_OFF;
      dp         <= DP_OFF;
      an         <= AN_OFF;
      frame_done <= 1'b0;
    end else begin
      en_d <= en;
      if (load) begin
        pend_code <= bcd_in;
        pend_dp   <= dp_in;
      end
      // Copy samples pending before this cycle's load, so a coincident load waits a frame.
      if (en && (!en_d || frame_end)) begin
        act_code <= pend_code;
        act_dp   <= pend_dp;
      end
      frame_done <= en && frame_end;
      if (!en) begin
        presc <= '0;
        idx   <= '0;
        seg   <= SEG_OFF;
        dp    <= DP_OFF;
        an    <= AN_OFF;
      end else begin
        presc <= slot_end ? '0 : presc + 1'b1;
        if (slot_end) idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
        seg <= lane_seg[idx] ^ SEG_OFF;
        dp  <= lane_dp[idx] ^ DP_OFF;
        an  <= cur_an ^ AN_OFF;
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: frame-level reference model of decode, blanking,
// slot timing and double buffering, with directed and random loads.
module tb_seg7_scan_driver;
  localparam int D = 4, RD = 4, BC = 1, FR = D * RD;

  logic        clk = 1'b0;
  logic        rst, en, load, blank_lz, dp, frame_done;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in, an;
  logic [6:0]  seg;

  int checks = 0, errors = 0;
  logic [12:0] obs [FR];   // {frame_done, dp, an, seg}
  logic [12:0] expv[FR];
  logic [6:0]  dec_tab[16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  seg7_scan_driver #(.DIGITS(D), .REFRESH_DIV(RD), .BLANK_CYC(BC), .HEX_EN(1),
                     .SEG_ACT_LOW(0), .AN_ACT_LOW(0)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .bcd_in(bcd_in), .dp_in(dp_in),
    .blank_lz(blank_lz), .seg(seg), .dp(dp), .an(an), .frame_done(frame_done));

  always #5 clk = ~clk;

  // Digit d is blank iff blanking is on, d>0, and every digit from d upward is code 0 without dp.
  function automatic logic [7:0] model_digit(input logic [15:0] c, input logic [3:0] p,
                                             input logic blz, input int d);
    logic blank;
    blank = blz && (d > 0);
    for (int j = d; j < D; j++) if (c[4*j +: 4] != 4'd0 || p[j]) blank = 1'b0;
    if (blank) return 8'h00;
    return {p[d], dec_tab[c[4*d +: 4]]};
  endfunction

  task automatic exp_frame(input logic [15:0] c, input logic [3:0] p, input logic blz);
    logic [7:0] m;
    for (int k = 0; k < FR; k++) begin
      m = model_digit(c, p, blz, k / RD);
      expv[k] = {(k == FR - 1), m[7], ((k % RD) < BC) ? 4'b0000 : 4'(1 << (k / RD)), m[6:0]};
    end
  endtask

  task automatic scan_frame;
    for (int k = 0; k < FR; k++) begin
      @(negedge clk);
      obs[k] = {frame_done, dp, an, seg};
    end
  endtask

  task automatic wait_fd;
    bit seen = 0;
    for (int i = 0; i < 4 * FR && !seen; i++) begin
      @(negedge clk);
      seen = frame_done;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wait_frame_done got no pulse within %0d cycles", 4 * FR);
    end
  endtask

  task automatic load_and_show(input logic [15:0] c, input logic [3:0] p, input logic blz);
    bcd_in = c; dp_in = p; blank_lz = blz; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_fd();
    scan_frame();
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; load = 1'b0; blank_lz = 1'b0; bcd_in = '0; dp_in = '0;
    repeat (3) @(negedge clk);
    checks++; if (seg !== 7'h00) begin errors++; $display("FAIL reset_seg got %h exp 00", seg); end
    checks++; if (an !== 4'h0) begin errors++; $display("FAIL reset_an got %h exp 0", an); end
    checks++; if (dp !== 1'b0) begin errors++; $display("FAIL reset_dp got %b exp 0", dp); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got %b exp 0", frame_done); end
    rst = 1'b0; en = 1'b1;
  endtask

  task automatic test_basic;
    bcd_in = 16'h1234; dp_in = '0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_fd();
    scan_frame();
    exp_frame(16'h1234, 4'h0, 1'b0);
    for (int k = 0; k < FR; k++) begin
      checks++;
      if (obs[k] !== expv[k]) begin errors++; $display("FAIL basic k=%0d got %h exp %h", k, obs[k], expv[k]); end
    end
  endtask

  task automatic test_lz;
    load_and_show(16'h00A5, 4'b0000, 1'b1);
    exp_frame(16'h00A5, 4'b0000, 1'b1);
    for (int k = 0; k < FR; k++) begin
      checks++;
      if (obs[k] !== expv[k]) begin errors++; $display("FAIL lz k=%0d got %h exp %h", k, obs[k], expv[k]); end
    end
    load_and_show(16'h00A5, 4'b0100, 1'b1);
    exp_frame(16'h00A5, 4'b0100, 1'b1);
    for (int k = 0; k < FR; k++) begin
      checks++;
      if (obs[k] !== expv[k]) begin errors++; $display("FAIL lz_dp k=%0d got %h exp %h", k, obs[k], expv[k]); end
    end
  endtask

  // Two loads in one frame: that frame keeps old data, next frame shows only the last load.
  task automatic test_back_to_back;
    for (int k = 0; k < FR; k++) begin
      if (k == 0) begin bcd_in = 16'h1111; dp_in = '0; load = 1'b1; end
      if (k == 1 || k == 6) load = 1'b0;
      if (k == 5) begin bcd_in = 16'h2222; load = 1'b1; end
      @(negedge clk);
      obs[k] = {frame_done, dp, an, seg};
    end
    exp_frame(16'h00A5, 4'b0100, 1'b1);
    for (int k = 0; k < FR; k++) begin
      checks++;
      if (obs[k] !== expv[k]) begin errors++; $display("FAIL b2b_old k=%0d got %h exp %h", k, obs[k], expv[k]); end
    end
    scan_frame();
    exp_frame(16'h2222, 4'b0000, 1'b1);
    for (int k = 0; k < FR; k++) begin
      checks++;
      if (obs[k] !== expv[k]) begin errors++; $display("FAIL b2b_new k=%0d got %h exp %h", k, obs[k], expv[k]); end
    end
  endtask

  // Load captured on the frame_done edge is shown one frame later.
  task automatic test_coincident;
    for (int k = 0; k < FR; k++) begin
      if (k == FR - 1) begin bcd_in = 16'hBEEF; dp_in = 4'b0001; load = 1'b1; end
      @(negedge clk);
      obs[k] = {frame_done, dp, an, seg};
    end
    load = 1'b0;
    scan_frame();
    exp_frame(16'h2222, 4'b0000, 1'b1);
    for (int k = 0; k < FR; k++) begin
      checks++;
      if (obs[k] !== expv[k]) begin errors++; $display("FAIL coinc_old k=%0d got %h exp %h", k, obs[k], expv[k]); end
    end
    scan_frame();
    exp_frame(16'hBEEF, 4'b0001, 1'b1);
    for (int k = 0; k < FR; k++) begin
      checks++;
      if (obs[k] !== expv[k]) begin errors++; $display("FAIL coinc_new k=%0d got %h exp %h", k, obs[k], expv[k]); end
    end
  endtask

  task automatic test_random;
    logic [15:0] cur_c = 16'hBEEF, nc;
    logic [3:0]  cur_p = 4'b0001, np;
    logic        nb;
    int          kl;
    for (int it = 0; it < 8; it++) begin
      for (int j = 0; j < D; j++) nc[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      np = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      nb = 1'($urandom);
      kl = $urandom_range(0, FR - 2);
      blank_lz = nb;
      for (int k = 0; k < FR; k++) begin
        if (k == kl) begin bcd_in = nc; dp_in = np; load = 1'b1; end
        if (k == kl + 1) load = 1'b0;
        @(negedge clk);
        obs[k] = {frame_done, dp, an, seg};
      end
      load = 1'b0;
      exp_frame(cur_c, cur_p, nb);
      for (int k = 0; k < FR; k++) begin
        checks++;
        if (obs[k] !== expv[k]) begin errors++; $display("FAIL random it=%0d k=%0d got %h exp %h", it, k, obs[k], expv[k]); end
      end
      cur_c = nc; cur_p = np;
    end
    scan_frame();
    exp_frame(cur_c, cur_p, blank_lz);
    for (int k = 0; k < FR; k++) begin
      checks++;
      if (obs[k] !== expv[k]) begin errors++; $display("FAIL random_last k=%0d got %h exp %h", k, obs[k], expv[k]); end
    end
  endtask

  task automatic test_enable;
    repeat (5) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    checks++;
    if ({frame_done, dp, an, seg} !== 13'h0) begin
      errors++; $display("FAIL en_off got %h exp 0000", {frame_done, dp, an, seg});
    end
    bcd_in = 16'h5678; dp_in = 4'b0010; blank_lz = 1'b0; load = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      load = 1'b0;
      checks++;
      if ({frame_done, dp, an, seg} !== 13'h0) begin
        errors++; $display("FAIL en_dark k=%0d got %h exp 0000", k, {frame_done, dp, an, seg});
      end
    end
    en = 1'b1;
    scan_frame();
    exp_frame(16'h5678, 4'b0010, 1'b0);
    for (int k = 0; k < FR; k++) begin
      checks++;
      if (obs[k] !== expv[k]) begin errors++; $display("FAIL en_restart k=%0d got %h exp %h", k, obs[k], expv[k]); end
    end
  endtask

  task automatic test_rst_mid;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({frame_done, dp, an, seg} !== 13'h0) begin
      errors++; $display("FAIL rst_async got %h exp 0000", {frame_done, dp, an, seg});
    end
    @(negedge clk);
    rst = 1'b0;
    wait_fd();
    scan_frame();
    exp_frame(16'h0000, 4'b0000, 1'b0);
    for (int k = 0; k < FR; k++) begin
      checks++;
      if (obs[k] !== expv[k]) begin errors++; $display("FAIL rst_zero k=%0d got %h exp %h", k, obs[k], expv[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lz();
    test_back_to_back();
    test_coincident();
    test_random();
    test_enable();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
